// File: rtl/efm_frame_sequencer_if.sv
// Bundle of EFM channel-bit input, LUT decoder handshake and decoded frame outputs.
// The sequencer attaches via slave; the environment (bit source + LUT) via master.
interface efm_frame_sequencer_if;
  logic        bit_in;
  logic        bit_valid;
  logic [13:0] efm_sym;
  logic [7:0]  lut_data;
  logic        lut_s0;
  logic        lut_s1;
  logic [7:0]  data_out;
  logic        data_valid;
  logic [4:0]  data_idx;
  logic [7:0]  sub_out;
  logic        sub_valid;
  logic        sub_s0;
  logic        sub_s1;
  logic        frame_start;
  logic        locked;

  modport slave (
    input  bit_in, bit_valid, lut_data, lut_s0, lut_s1,
    output efm_sym, data_out, data_valid, data_idx, sub_out, sub_valid,
           sub_s0, sub_s1, frame_start, locked
  );

  modport master (
    output bit_in, bit_valid, lut_data, lut_s0, lut_s1,
    input  efm_sym, data_out, data_valid, data_idx, sub_out, sub_valid,
           sub_s0, sub_s1, frame_start, locked
  );
endinterface

// File: rtl/efm_frame_sequencer.sv
// EFM frame sequencer: finds the 24-bit frame sync, flywheels over missed syncs and
// slices each 588-bit frame into 33 symbols sent through an external combinational LUT.
module efm_frame_sequencer #(
  parameter int MISS_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  efm_frame_sequencer_if.slave  bus
);

  localparam logic [23:0] SYNC_PAT  = 24'h801002;
  localparam logic [9:0]  P_LAST    = 10'd587;
  localparam logic [4:0]  SLOT_LAST = 5'd16;
  localparam logic [4:0]  SLOT_SYM  = 5'd13;
  localparam logic [4:0]  SLOT_INIT = 5'd14;
  localparam logic [5:0]  NUM_SYMS  = 6'd33;

  typedef enum logic {HUNT, LOCK} state_t;

  state_t      state_reg, state_next;
  logic [23:0] sr_reg, sr_next;
  logic [9:0]  p_reg, p_next;
  logic [4:0]  slot_reg, slot_next;
  logic [5:0]  k_reg, k_next;
  logic [2:0]  miss_reg, miss_next;
  logic        pend_reg, pend_next;
  logic [5:0]  pend_k_reg, pend_k_next;
  logic [13:0] efm_sym_reg, efm_sym_next;
  logic [7:0]  data_out_reg, data_out_next;
  logic        data_valid_reg, data_valid_next;
  logic [4:0]  data_idx_reg, data_idx_next;
  logic [7:0]  sub_out_reg, sub_out_next;
  logic        sub_valid_reg, sub_valid_next;
  logic        sub_s0_reg, sub_s0_next;
  logic        sub_s1_reg, sub_s1_next;
  logic        frame_start_reg, frame_start_next;

  logic [23:0] sr_shift;
  logic        sync_match;

  assign sr_shift   = {sr_reg[22:0], bus.bit_in};
  assign sync_match = (sr_shift == SYNC_PAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= HUNT;
      sr_reg          <= '0;
      p_reg           <= '0;
      slot_reg        <= '0;
      k_reg           <= '0;
      miss_reg        <= '0;
      pend_reg        <= 1'b0;
      pend_k_reg      <= '0;
      efm_sym_reg     <= '0;
      data_out_reg    <= '0;
      data_valid_reg  <= 1'b0;
      data_idx_reg    <= '0;
      sub_out_reg     <= '0;
      sub_valid_reg   <= 1'b0;
      sub_s0_reg      <= 1'b0;
      sub_s1_reg      <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      sr_reg          <= sr_next;
      p_reg           <= p_next;
      slot_reg        <= slot_next;
      k_reg           <= k_next;
      miss_reg        <= miss_next;
      pend_reg        <= pend_next;
      pend_k_reg      <= pend_k_next;
      efm_sym_reg     <= efm_sym_next;
      data_out_reg    <= data_out_next;
      data_valid_reg  <= data_valid_next;
      data_idx_reg    <= data_idx_next;
      sub_out_reg     <= sub_out_next;
      sub_valid_reg   <= sub_valid_next;
      sub_s0_reg      <= sub_s0_next;
      sub_s1_reg      <= sub_s1_next;
      frame_start_reg <= frame_start_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    sr_next          = sr_reg;
    p_next           = p_reg;
    slot_next        = slot_reg;
    k_next           = k_reg;
    miss_next        = miss_reg;
    pend_next        = 1'b0;
    pend_k_next      = pend_k_reg;
    efm_sym_next     = efm_sym_reg;
    frame_start_next = 1'b0;

    if (bus.bit_valid) begin
      sr_next = sr_shift;
      case (state_reg)
        HUNT: begin
          if (sync_match) begin
            state_next       = LOCK;
            p_next           = '0;
            slot_next        = SLOT_INIT;
            k_next           = '0;
            miss_next        = '0;
            frame_start_next = 1'b1;
          end
        end
        LOCK: begin
          // slot counts 0..16 within a 17-bit symbol cell; it starts at 14 so the
          // three merging bits after sync wrap it to 0 at the first symbol bit.
          if (slot_reg == SYM_END_SLOT() && k_reg < NUM_SYMS) begin
            pend_next    = 1'b1;
            pend_k_next  = k_reg;
            k_next       = k_reg + 6'd1;
            efm_sym_next = sr_shift[13:0];
          end
          slot_next = (slot_reg == SLOT_LAST) ? 5'd0 : slot_reg + 5'd1;
          if (p_reg == P_LAST) begin
            p_next    = '0;
            slot_next = SLOT_INIT;
            k_next    = '0;
            if (sync_match) begin
              frame_start_next = 1'b1;
              miss_next        = '0;
            end else if (int'(miss_reg) + 1 >= MISS_MAX) begin
              state_next = HUNT;
              miss_next  = '0;
            end else begin
              miss_next = miss_reg + 3'd1;
            end
          end else begin
            p_next = p_reg + 10'd1;
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  function automatic logic [4:0] SYM_END_SLOT();
    return SLOT_SYM;
  endfunction

  // Second pipeline stage: capture the LUT answer for the symbol latched last cycle.
  always_comb begin
    data_out_next   = data_out_reg;
    data_idx_next   = data_idx_reg;
    sub_out_next    = sub_out_reg;
    sub_s0_next     = sub_s0_reg;
    sub_s1_next     = sub_s1_reg;
    data_valid_next = 1'b0;
    sub_valid_next  = 1'b0;
    if (pend_reg) begin
      if (pend_k_reg == 6'd0) begin
        sub_valid_next = 1'b1;
        sub_out_next   = bus.lut_data;
        sub_s0_next    = bus.lut_s0;
        sub_s1_next    = bus.lut_s1;
      end else begin
        data_valid_next = 1'b1;
        data_out_next   = bus.lut_data;
        data_idx_next   = 5'(pend_k_reg - 6'd1);
      end
    end
  end

  assign bus.efm_sym     = efm_sym_reg;
  assign bus.data_out    = data_out_reg;
  assign bus.data_valid  = data_valid_reg;
  assign bus.data_idx    = data_idx_reg;
  assign bus.sub_out     = sub_out_reg;
  assign bus.sub_valid   = sub_valid_reg;
  assign bus.sub_s0      = sub_s0_reg;
  assign bus.sub_s1      = sub_s1_reg;
  assign bus.frame_start = frame_start_reg;
  assign bus.locked      = (state_reg == LOCK);

endmodule

// File: tb/tb_efm_frame_sequencer.sv
// Bench for efm_frame_sequencer: builds channel-bit streams, predicts every strobe from
// frame positions in the stream, and compares against the observed event log.
module tb_efm_frame_sequencer;
  localparam int          MISS_MAX = 3;
  localparam logic [23:0] SYNC     = 24'h801002;
  localparam logic [23:0] BAD_SYNC = 24'h801003;
  localparam logic [13:0] S0       = 14'b00100000000001;
  localparam logic [13:0] S1       = 14'b00000000010010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  efm_frame_sequencer_if bus();
  efm_frame_sequencer #(.MISS_MAX(MISS_MAX)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Bench symbol code: never holds more than 3 zeros in a row, so sync cannot appear in data.
  function automatic logic [13:0] enc(input logic [7:0] b);
    return {2'b10, b[7:6], 1'b1, b[5:3], 1'b1, b[2:0], 2'b10};
  endfunction
  function automatic logic [7:0] dec(input logic [13:0] s);
    return {s[11:10], s[8:6], s[4:2]};
  endfunction

  assign bus.lut_data = dec(bus.efm_sym);
  assign bus.lut_s0   = (bus.efm_sym == S0);
  assign bus.lut_s1   = (bus.efm_sym == S1);

  typedef struct {
    int kind;  // 0 sub, 1 data, 2 frame_start, 3 locked change
    int val;
    int aux;
    int cyc;
  } ev_t;

  typedef struct {
    logic [7:0] in_byte;
    logic [4:0] exp_idx;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[32];
  ev_t  obs[$];
  ev_t  expq[$];
  bit   stream[$];
  int   acc[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic last_locked = 1'b0;

  function automatic ev_t mk(input int kind, input int val, input int aux, input int c);
    ev_t e;
    e.kind = kind; e.val = val; e.aux = aux; e.cyc = c;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.sub_valid)   obs.push_back(mk(0, int'(bus.sub_out), int'({bus.sub_s1, bus.sub_s0}), cyc));
    if (bus.data_valid)  obs.push_back(mk(1, int'(bus.data_out), int'(bus.data_idx), cyc));
    if (bus.frame_start) obs.push_back(mk(2, 0, 0, cyc));
    if (bus.locked !== last_locked) obs.push_back(mk(3, int'(bus.locked), 0, cyc));
    last_locked = bus.locked;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_zero(input string name);
    chk({name, " efm_sym"},     int'(bus.efm_sym), 0);
    chk({name, " data_out"},    int'(bus.data_out), 0);
    chk({name, " data_idx"},    int'(bus.data_idx), 0);
    chk({name, " data_valid"},  int'(bus.data_valid), 0);
    chk({name, " sub_out"},     int'(bus.sub_out), 0);
    chk({name, " sub_valid"},   int'(bus.sub_valid), 0);
    chk({name, " sub_flags"},   int'({bus.sub_s1, bus.sub_s0}), 0);
    chk({name, " frame_start"}, int'(bus.frame_start), 0);
    chk({name, " locked"},      int'(bus.locked), 0);
  endtask

  task automatic push_bits(input logic [23:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) stream.push_back(v[i]);
  endtask

  task automatic push_head();
    push_bits(24'h00AAAA, 16);
    push_bits(SYNC, 24);
  endtask

  // 3 merging bits, 33 symbol cells of 14+3 bits, then the sync that closes the frame.
  task automatic push_frame(input logic [13:0] sym0, input bit use_rand, input logic [23:0] end_sync);
    logic [7:0] b;
    push_bits(24'h000001, 3);
    push_bits({10'd0, sym0}, 14);
    push_bits(24'h000001, 3);
    for (int k = 1; k <= 32; k++) begin
      b = use_rand ? 8'($urandom) : tbl[k-1].in_byte;
      push_bits({10'd0, enc(b)}, 14);
      push_bits(24'h000001, 3);
    end
    push_bits(end_sync, 24);
  endtask

  task automatic drive_stream(input int vmode);
    int  j = 0;
    int  t = 0;
    bit  v;
    acc.delete();
    while (j < stream.size()) begin
      @(posedge clk); #1;
      case (vmode)
        0:       v = 1'b1;
        1:       v = (t % 4 == 0) || (t % 4 == 3);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      t++;
      bus.bit_valid = v;
      bus.bit_in    = v ? stream[j] : 1'($urandom);
      if (v) begin
        acc.push_back(cyc);
        j++;
      end
    end
    @(posedge clk); #1;
    bus.bit_valid = 1'b0;
  endtask

  // Reference: walk the stream by frame position (sync end, 17-bit cells, 588-bit frames).
  task automatic build_exp(input bit rst_end, input int r);
    logic [23:0] sr = '0;
    logic [13:0] s;
    bit lk = 1'b0;
    int p = 0;
    int miss = 0;
    int k;
    int c;
    expq.delete();
    for (int j = 0; j < stream.size(); j++) begin
      sr = {sr[22:0], stream[j]};
      c  = acc[j];
      if (!lk) begin
        if (sr == SYNC) begin
          lk = 1'b1; p = 0; miss = 0;
          expq.push_back(mk(2, 0, 0, c + 1));
          expq.push_back(mk(3, 1, 0, c + 1));
        end
        continue;
      end
      if (p >= 3 && p <= 563 && (p - 3) % 17 == 13) begin
        k = (p - 3) / 17;
        s = sr[13:0];
        if (k == 0) expq.push_back(mk(0, int'(dec(s)), int'({s == S1, s == S0}), c + 2));
        else        expq.push_back(mk(1, int'(dec(s)), k - 1, c + 2));
      end
      if (p == 587) begin
        p = 0;
        if (sr == SYNC) begin
          miss = 0;
          expq.push_back(mk(2, 0, 0, c + 1));
        end else begin
          miss++;
          if (miss == MISS_MAX) begin
            lk = 1'b0; miss = 0;
            expq.push_back(mk(3, 0, 0, c + 1));
          end
        end
      end else begin
        p++;
      end
    end
    if (rst_end) begin
      while (expq.size() > 0 && expq[expq.size()-1].cyc >= r + 1) void'(expq.pop_back());
      if (lk) expq.push_back(mk(3, 0, 0, r + 1));
    end
  endtask

  task automatic compare(input string name);
    int n;
    chk({name, " event count"}, obs.size(), expq.size());
    n = (obs.size() < expq.size()) ? obs.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      n_chk++;
      if (obs[i].kind != expq[i].kind || obs[i].val != expq[i].val ||
          obs[i].aux != expq[i].aux || obs[i].cyc != expq[i].cyc) begin
        n_fail++;
        $display("FAIL %s event %0d: got kind=%0d val=0x%0h aux=%0d cyc=%0d, expected kind=%0d val=0x%0h aux=%0d cyc=%0d",
                 name, i, obs[i].kind, obs[i].val, obs[i].aux, obs[i].cyc,
                 expq[i].kind, expq[i].val, expq[i].aux, expq[i].cyc);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.bit_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_scn(input string name, input int vmode, input bit rst_end);
    int r = 0;
    @(negedge clk); #1;
    obs.delete();
    drive_stream(vmode);
    if (rst_end) begin
      rst = 1'b1;
      r = cyc;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_zero({name, " post-rst"});
      repeat (4) @(posedge clk);
    end else begin
      repeat (6) @(posedge clk);
    end
    @(negedge clk); #1;
    build_exp(rst_end, r);
    compare(name);
    stream.delete();
  endtask

  function automatic int count_kind(input int kind);
    int n = 0;
    foreach (obs[i]) if (obs[i].kind == kind) n++;
    return n;
  endfunction

  task automatic check_table(input string name);
    ev_t d[$];
    int  nsub = 0;
    foreach (obs[i]) begin
      if (obs[i].kind == 1) d.push_back(obs[i]);
      if (obs[i].kind == 0) begin
        nsub++;
        chk({name, " sub_s0/s1"}, obs[i].aux, 1);
      end
    end
    chk({name, " sub count"}, nsub, 1);
    chk({name, " data count"}, d.size(), 32);
    for (int i = 0; i < 32 && i < d.size(); i++) begin
      chk($sformatf("%s data_out[%0d]", name, i), d[i].val, int'(tbl[i].exp_data));
      chk($sformatf("%s data_idx[%0d]", name, i), d[i].aux, int'(tbl[i].exp_idx));
    end
  endtask

  initial begin
    int base;
    logic [23:0] sv;
    bus.bit_in = 1'b0;
    bus.bit_valid = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tbl[k-1].in_byte  = 8'(k);
      tbl[k-1].exp_idx  = 5'(k - 1);
      tbl[k-1].exp_data = 8'(k);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    #1 rst = 1'b0;

    // Clean frame with S0 subcode and bytes 0x01..0x20, continuous bits.
    push_head(); push_frame(S0, 1'b0, SYNC);
    run_scn("basic", 0, 1'b0);
    check_table("basic");

    // Same frame with bit_valid 1-0-0-1: same data, stretched timing.
    do_reset();
    push_head(); push_frame(S0, 1'b0, SYNC);
    run_scn("stretched", 1, 1'b0);
    check_table("stretched");

    // Second sync corrupted: flywheel keeps lock and emits every symbol.
    do_reset();
    push_head();
    push_frame(S1, 1'b1, BAD_SYNC);
    push_frame(S0, 1'b1, SYNC);
    push_frame(S1, 1'b1, SYNC);
    run_scn("flywheel", 2, 1'b0);
    chk("flywheel subs", count_kind(0), 3);
    chk("flywheel data", count_kind(1), 96);
    chk("flywheel frame_starts", count_kind(2), 3);
    chk("flywheel lock edges", count_kind(3), 1);

    // Three bad syncs in a row lose lock; a later sync relocks.
    do_reset();
    push_head();
    push_frame(S0, 1'b1, BAD_SYNC);
    push_frame(S0, 1'b1, BAD_SYNC);
    push_frame(S0, 1'b1, BAD_SYNC);
    push_bits(SYNC, 24);
    push_frame(S1, 1'b1, SYNC);
    run_scn("lock loss", 2, 1'b0);
    chk("lock loss subs", count_kind(0), 4);
    chk("lock loss lock edges", count_kind(3), 3);

    // Sync pattern planted at p=177..200 while locked is ignored.
    do_reset();
    push_head();
    base = stream.size();
    push_frame(S0, 1'b1, SYNC);
    sv = SYNC;
    for (int i = 0; i < 24; i++) stream[base + 177 + i] = sv[23 - i];
    push_frame(S1, 1'b1, SYNC);
    run_scn("embedded sync", 2, 1'b0);
    chk("embedded frame_starts", count_kind(2), 3);
    chk("embedded data", count_kind(1), 64);

    // One-cycle reset with the next bit at p=300, then relock from index 0.
    do_reset();
    push_head();
    base = stream.size();
    push_frame(S0, 1'b1, SYNC);
    while (stream.size() > base + 300) void'(stream.pop_back());
    run_scn("rst p300", 0, 1'b1);
    push_head(); push_frame(S0, 1'b0, SYNC);
    run_scn("relock", 0, 1'b0);
    check_table("relock");

    // Reset the cycle after a symbol's last bit: its strobe is discarded.
    do_reset();
    push_head();
    base = stream.size();
    push_frame(S0, 1'b1, SYNC);
    while (stream.size() > base + 102) void'(stream.pop_back());
    run_scn("rst inflight", 0, 1'b1);
    chk("rst inflight data", count_kind(1), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/efm_frame_sequencer.md
EFM_FRAME_SEQUENCER -- requirements
Module: efm_frame_sequencer

Interface
REQ-001 SHALL have parameter MISS_MAX, default 3, meaning consecutive missed syncs tolerated before lock loss (range 1..7).
REQ-002 SHALL provide ports as follows; one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 bit_in  input  1  channel bit (NRZ-decoded EFM stream, MSB-first per symbol).
REQ-006 bit_valid  input  1  bit_in qualifier; one channel bit accepted per cycle when high.
REQ-007 efm_sym  output  14  registered 14-bit EFM symbol presented to the combinational LUT decoder.
REQ-008 lut_data  input  8  decoded byte returned by LUT for efm_sym (same cycle).
REQ-009 lut_s0, lut_s1  input  1 each  LUT subcode-sync flags for efm_sym.
REQ-010 data_out  output  8  decoded data byte; data_valid output 1, one-cycle strobe; data_idx output 5, byte index 0..31 in frame.
REQ-011 sub_out  output  8, sub_valid output 1, sub_s0/sub_s1 output 1 each: subcode symbol result and flags.
REQ-012 frame_start  output  1  one-cycle pulse on every accepted sync; locked  output  1  lock state.

Function
REQ-013 SHALL shift each accepted bit into a 24-bit register, shift-left, new bit into LSB.
REQ-014 Sync match SHALL be register == 24'h801002 evaluated including the bit accepted in that cycle.
REQ-015 SHALL implement states HUNT and LOCK; locked=1 only in LOCK.
REQ-016 HUNT: on sync match -> LOCK, position counter p=0 for the next accepted bit, miss count=0, frame_start pulse.
REQ-017 p SHALL count accepted bits after sync end, range 0..587, advancing only on bit_valid; never counts in HUNT.
REQ-018 Frame layout after sync: p=0..2 merging bits; symbol k (k=0..32) occupies p=3+17k .. 16+17k (14 symbol bits then 3 merging bits); p=564..587 next sync.
REQ-019 Symbol k complete when bit p=16+17k accepted... precisely when p==3+17k+13 is accepted; the 14 most recent bits SHALL be latched into efm_sym on the following edge (cycle N+1).
REQ-020 At cycle N+2 (registered from LUT response in N+1): k=0 -> sub_valid=1, sub_out=lut_data, sub_s0/sub_s1=LUT flags; k=1..32 -> data_valid=1, data_out=lut_data, data_idx=k-1.
REQ-021 Strobes SHALL be single-cycle; efm_sym and data/sub outputs SHALL hold value between strobes.
REQ-022 At p==587 accepted: match -> frame_start pulse, miss count=0, p=0; no match -> miss count+1, p=0 (flywheel, frame timing retained, no frame_start).
REQ-023 Miss count reaching MISS_MAX SHALL force HUNT on the same edge; symbols of the flywheel frame already emitted stay valid.
REQ-024 In LOCK, a sync pattern at any p other than 587 SHALL be ignored.
REQ-025 bit_valid low SHALL freeze shift register, p and state; pending N+1/N+2 pipeline stages SHALL still complete.
REQ-026 Exactly 1 sub_valid and 32 data_valid strobes SHALL occur per locked frame, in order.

Reset
REQ-027 rst SHALL force: HUNT, p=0, miss count=0, shift register=0, efm_sym=0, data_out=0, sub_out=0, all strobes/flags 0, locked=0.
REQ-028 rst asserted mid-frame SHALL discard in-flight symbol pipeline (no strobe in the cycle after rst deasserts).

Verification
REQ-029 Continuous bit_valid, sync then 33 symbols coding 0x00..0x20 (symbol 0 = S0 pattern) -> frame_start, locked=1, sub_valid with sub_s0=1, data_idx 0..31 with data_out 0x01..0x20, each 2 cycles after last symbol bit.
REQ-030 Three frames, second sync corrupted (MISS_MAX=3) -> locked stays 1, no frame_start for frame 2, all 99 strobes emitted.
REQ-031 Three consecutive corrupted syncs -> locked falls on the third p==587 bit; no strobes until next valid sync.
REQ-032 bit_valid toggling 1-0-0-1 throughout a frame -> identical data_out sequence to REQ-029, only timing stretched.
REQ-033 Sync pattern embedded at p=200 while locked -> no frame_start, frame timing unchanged.
REQ-034 rst for 1 cycle at p=300 -> all outputs 0, locked=0; relock on next sync with data_idx restarting at 0.
